pipe_stage: RTL and testbench
=============================

# pipe_stage

Parametrised pipeline register stage with a valid/ready handshake, flush, and a saturating stall counter. It replaces fixed-field, enable-driven pipeline latches between the decode, execute and memory stages. The stage holds an opaque WIDTH-bit payload formed by concatenating the stage's control fields. Back-pressure propagates upstream through in_ready instead of a global enable.

## Interface
- WIDTH, 64: payload width in bits (≥1).
- CNT_W, 16: stall counter width (≥2).
- CLEAR_ON_FLUSH, 1: 1 zeroes all payload registers on flush; 0 leaves the payload unchanged and clears only the valid state.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage accepts a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload presented downstream.
- flush  in  1  discard all held and incoming payloads.
- occupancy  out  2  number of entries held (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- Storage consists of a main register (drives out_data) and a skid register (only with PIPE_STAGE_SKID_EN).
- States (skid build):
  - EMPTY (occ 0)
  - ONE (main full)
  - TWO (main and skid full)
- Transitions:
  - EMPTY, in_fire → ONE; main <= in_data.
  - ONE, in_fire & out_fire → ONE; main <= in_data.
  - ONE, in_fire & !out_fire → TWO; skid <= in_data.
  - ONE, !in_fire & out_fire → EMPTY.
  - TWO, out_fire → ONE; main <= skid.
  - TWO, !out_fire → hold.
- out_valid = (state != EMPTY). in_ready is registered: 1 exactly when the next state is not TWO.
- Priority order: reset, then flush, then handshake.
- Flush:
  - Next state is EMPTY.
  - An in_fire in the flush cycle is dropped.
  - An out_fire in the flush cycle counts as delivered.
  - Payload registers zero only if CLEAR_ON_FLUSH=1.
- stall_cnt:
  - Increments when out_valid & !out_ready.
  - Holds at all-ones once saturated.
  - Unaffected by flush; cleared only by reset.
- Payload bits are never interpreted or modified by the stage.

## Timing
- Reset (reset=0 at a rising edge) sets:
  - state EMPTY, out_valid 0, out_data 0, skid 0
  - occupancy 0, stall_cnt 0
  - in_ready 0 while reset is low; in_ready 1 on the first cycle after release.
- Latency: a payload accepted at edge N appears on out_data, with out_valid=1, after edge N.
- Throughput: one transfer per cycle when out_ready stays 1.
- Handshake rules:
  - out_data and out_valid are stable while out_valid & !out_ready (no drop, no change).
  - in_valid may be asserted independently of in_ready.
- Reset released mid-transfer: the first valid payload is accepted only when in_ready=1.

## Configuration
- PIPE_STAGE_SKID_EN defined:
  - Two-entry skid buffer; in_ready is a register output with no combinational path from out_ready.
  - occupancy ranges 0..2.
- Not defined:
  - Single main register; in_ready = reset & (!out_valid | out_ready), combinational.
  - States EMPTY and ONE only; occupancy ranges 0..1.
  - Handshake, flush and stall_cnt rules are otherwise identical.

## Test plan
- Streaming: reset, out_ready=1, push 0x1..0x10 back-to-back.
  - out_data yields 0x1..0x10 in order, each one cycle after acceptance, with no bubbles.
  - occupancy stays ≤1.
- Back-pressure (skid build): push 0xA, 0xB, 0xC with out_ready=0.
  - 0xA and 0xB are accepted; occupancy=2; in_ready=0; 0xC is held upstream.
  - After raising out_ready: outputs 0xA, 0xB, 0xC in order.
- Flush: occupancy=2, flush=1 with in_valid=1 (data 0xD).
  - Next cycle: out_valid=0, occupancy=0; 0xD never appears.
  - out_data=0 if CLEAR_ON_FLUSH=1, else unchanged.
- Stall saturation: CNT_W=2, out_valid held with out_ready=0 for 6 cycles.
  - stall_cnt reads 1, 2, 3, 3, 3, 3.
  - A following flush leaves it at 3.
- Reset mid-operation: reset=0 while occupancy=2 and stall_cnt=5.
  - Next cycle: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=0.
  - in_ready=1 one cycle after release.
- Non-skid build: out_ready=0 with main full.
  - in_ready=0 in the same cycle.
  - Raising out_ready raises in_ready combinationally; a simultaneous push and pop keeps occupancy=1.

Source files
------------

// File: rtl/pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
//
// Pipeline register stage with a valid/ready handshake, flush and a saturating
// stall counter. The payload is opaque: it is stored and forwarded, never
// interpreted.
//
// Build option:
//   PIPE_STAGE_SKID_EN  defined   -> two-entry skid buffer (main + skid),
//                                    in_ready is a register output.
//                       undefined -> single main register, in_ready is
//                                    combinational from out_valid/out_ready.
//
// Parameters:
//   WIDTH           payload width in bits
//   CNT_W           stall counter width
//   CLEAR_ON_FLUSH  1: flush zeroes payload registers, 0: flush keeps them
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-low reset
//   in_valid   upstream payload valid
//   in_ready   stage accepts a payload this cycle
//   in_data    upstream payload
//   out_valid  out_data holds a valid payload
//   out_ready  downstream accepts this cycle
//   out_data   payload presented downstream
//   flush      discard all held and incoming payloads
//   occupancy  number of entries held (0..2)
//   stall_cnt  saturating count of cycles with out_valid=1 and out_ready=0
// -----------------------------------------------------------------------------
module pipe_stage #(
    parameter int WIDTH          = 64,
    parameter int CNT_W          = 16,
    parameter bit CLEAR_ON_FLUSH = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             flush,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    // Encoding equals the number of held entries so occupancy is the state.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [CNT_W-1:0] stall_q;
    logic             in_fire, out_fire;

    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign occupancy = 2'(state_q);
    assign stall_cnt = stall_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;

    // Registered: no combinational path from out_ready to in_ready.
    assign in_ready = in_ready_q;
`else
    // Single entry: we can take a new payload if empty or if the held one
    // leaves this cycle. Held low during reset.
    assign in_ready = reset & (~out_valid | out_ready);
`endif

    // NOTE: every output of this block is given its hold value first, so no
    // path through the branches leaves a signal unassigned (no latches).
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            // Flush beats the handshake: any incoming payload is dropped, an
            // outgoing one has already been seen by downstream.
            state_d = EMPTY;
            if (CLEAR_ON_FLUSH) begin
                main_d = '0;
`ifdef PIPE_STAGE_SKID_EN
                skid_d = '0;
`endif
            end
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
                    end else if (in_fire) begin
                        // Downstream stalled: park the new payload in skid.
                        state_d = TWO;
                        skid_d  = in_data;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (out_fire) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
`endif
                default: state_d = EMPTY;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: payload registers are reset too, because out_data must
            // read zero after reset rather than stale data.
            state_q <= EMPTY;
            main_q  <= '0;
            stall_q <= '0;
`ifdef PIPE_STAGE_SKID_EN
            skid_q     <= '0;
            in_ready_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            // Stall counting ignores flush; only reset clears it.
            if (out_valid && !out_ready && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
`ifdef PIPE_STAGE_SKID_EN
            skid_q     <= skid_d;
            in_ready_q <= (state_d != TWO);
`endif
        end
    end

endmodule

// File: tb/tb_pipe_stage.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage
//
// Two instances share all inputs: u_dut (defaults: CNT_W=16, CLEAR_ON_FLUSH=1)
// and u_sat (CNT_W=2, CLEAR_ON_FLUSH=0). A queue model of the held payloads is
// updated every cycle; outputs are compared on the falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_stage;

    localparam int WIDTH = 64;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic             flush;

    logic             in_ready,  in_ready_s;
    logic             out_valid, out_valid_s;
    logic [WIDTH-1:0] out_data,  out_data_s;
    logic [1:0]       occupancy, occupancy_s;
    logic [15:0]      stall_cnt;
    logic [1:0]       stall_cnt_s;

    always #5 clk = ~clk;

    pipe_stage #(.WIDTH(WIDTH), .CNT_W(16), .CLEAR_ON_FLUSH(1'b1)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    pipe_stage #(.WIDTH(WIDTH), .CNT_W(2), .CLEAR_ON_FLUSH(1'b0)) u_sat (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready_s),
        .in_data   (in_data),
        .out_valid (out_valid_s),
        .out_ready (out_ready),
        .out_data  (out_data_s),
        .flush     (flush),
        .occupancy (occupancy_s),
        .stall_cnt (stall_cnt_s)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Scoreboard / model state
    logic [WIDTH-1:0] q[$];       // payloads held by the stage, front = out_data
    logic [WIDTH-1:0] stim[$];    // payloads waiting upstream
    logic [15:0]      stall_m = '0;
    logic [1:0]       stall_s = '0;
    logic [WIDTH-1:0] idle_m  = '0;  // out_data of u_dut when nothing is held
    logic [WIDTH-1:0] idle_s  = '0;  // out_data of u_sat when nothing is held
    bit               in_rst_m = 1'b1;
    bit               fire_m   = 1'b0;

    // One clock cycle: compare on the falling edge, advance the model for the
    // coming rising edge, return 1 time unit after that edge.
    task automatic cycle();
        logic exp_rdy, in_f, out_f;
        @(negedge clk);
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = !in_rst_m && (q.size() < 2);
`else
        exp_rdy = reset && ((q.size() == 0) || out_ready);
`endif
        check("in_ready",    64'(in_ready),    64'(exp_rdy));
        check("in_ready_s",  64'(in_ready_s),  64'(exp_rdy));
        check("out_valid",   64'(out_valid),   64'(q.size() != 0));
        check("out_valid_s", 64'(out_valid_s), 64'(q.size() != 0));
        check("occupancy",   64'(occupancy),   64'(q.size()));
        check("occupancy_s", 64'(occupancy_s), 64'(q.size()));
        check("stall_cnt",   64'(stall_cnt),   64'(stall_m));
        check("stall_sat",   64'(stall_cnt_s), 64'(stall_s));
        if (q.size() != 0) begin
            check("out_data",   out_data,   q[0]);
            check("out_data_s", out_data_s, q[0]);
        end else begin
            check("idle_data",   out_data,   idle_m);
            check("idle_data_s", out_data_s, idle_s);
        end

        in_f   = in_valid && exp_rdy;
        out_f  = (q.size() != 0) && out_ready;
        fire_m = 1'b0;
        if (!reset) begin
            q.delete();
            stall_m  = '0;
            stall_s  = '0;
            idle_m   = '0;
            idle_s   = '0;
            in_rst_m = 1'b1;
        end else begin
            in_rst_m = 1'b0;
            if ((q.size() != 0) && !out_ready) begin
                if (stall_m != 16'hFFFF) stall_m++;
                if (stall_s != 2'b11)    stall_s++;
            end
            fire_m = in_f;
            if (flush) begin
                if (q.size() != 0) idle_s = q[0];
                idle_m = '0;
                q.delete();
            end else begin
                if (out_f) begin
                    idle_m = q[0];
                    idle_s = q[0];
                    void'(q.pop_front());
                end
                if (in_f) q.push_back(in_data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Offer the head of stim upstream for one cycle.
    task automatic step_stim();
        in_valid = (stim.size() != 0);
        in_data  = (stim.size() != 0) ? stim[0] : '0;
        cycle();
        if (fire_m) void'(stim.pop_front());
    endtask

    task automatic run(input int ncyc);
        for (int i = 0; i < ncyc; i++) step_stim();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        out_ready = 1'b1;
        while (((q.size() != 0) || (stim.size() != 0)) && (n < budget)) begin
            step_stim();
            n++;
        end
        in_valid = 1'b0;
        check(tag, 64'(out_valid), 64'(0));
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state, with upstream already trying to push.
        in_valid = 1'b1;
        in_data  = 64'h99;
        cycle();
        cycle();
        check("rst_out_data", out_data, 64'h0);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        reset    = 1'b1;

        // Streaming 0x1..0x10 with out_ready held high.
        out_ready = 1'b1;
        for (int v = 1; v <= 16; v++) stim.push_back(64'(v));
        drain("stream_done", 60);

        // Back-pressure: 0xA, 0xB, 0xC with downstream stalled for 6 cycles.
        out_ready = 1'b0;
        stim.push_back(64'hA);
        stim.push_back(64'hB);
        stim.push_back(64'hC);
        run(7);
        check("bp_occupancy", 64'(occupancy), 64'(DEPTH));
        check("bp_in_ready",  64'(in_ready),  64'(0));
        check("bp_stall_sat", 64'(stall_cnt_s), 64'(3));
        drain("bp_done", 20);

        // Flush while full, with 0xD offered in the flush cycle.
        out_ready = 1'b0;
        stim.push_back(64'h21);
        stim.push_back(64'h22);
        run(4);
        stim.delete();
        stim.push_back(64'hD);
        flush = 1'b1;
        run(1);
        flush = 1'b0;
        stim.delete();
        check("flush_occ",    64'(occupancy), 64'(0));
        check("flush_valid",  64'(out_valid), 64'(0));
        check("flush_data",   out_data,   64'h0);
        check("flush_data_s", out_data_s, 64'h21);
        check("flush_stall",  64'(stall_cnt_s), 64'(3));
        cycle();
        for (int v = 'h50; v < 'h54; v++) stim.push_back(64'(v));
        drain("post_flush_done", 20);

        // Reset mid-operation while full and stalled.
        out_ready = 1'b0;
        stim.push_back(64'h31);
        stim.push_back(64'h32);
        stim.push_back(64'h33);
        run(6);
        stim.delete();
        stim.push_back(64'h40);
        reset = 1'b0;
        run(2);
        check("mid_rst_valid", 64'(out_valid), 64'(0));
        check("mid_rst_data",  out_data,       64'h0);
        check("mid_rst_occ",   64'(occupancy), 64'(0));
        check("mid_rst_stall", 64'(stall_cnt), 64'(0));
        check("mid_rst_rdy",   64'(in_ready),  64'(0));
        reset = 1'b1;
        out_ready = 1'b1;
        run(3);
        check("post_rst_rdy", 64'(in_ready), 64'(1));
        drain("post_rst_done", 20);

        // Randomised traffic with occasional flushes.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid || fire_m) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom};
            end
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            cycle();
        end
        flush = 1'b0;
        drain("random_done", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
